// File: rtl/seg7_pkg.sv
// Shared types and helpers for the seven-segment scan decoder.
// Segment patterns are active-high (lit = 1), bit0 = segment a ... bit6 = segment g.
package seg7_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StHeld
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] nibble;
  } seg7_dec_t;

  localparam logic [6:0] Seg7Pat0 = 7'h3F;
  localparam logic [6:0] Seg7Pat1 = 7'h06;
  localparam logic [6:0] Seg7Pat2 = 7'h5B;
  localparam logic [6:0] Seg7Pat3 = 7'h4F;
  localparam logic [6:0] Seg7Pat4 = 7'h66;
  localparam logic [6:0] Seg7Pat5 = 7'h6D;
  localparam logic [6:0] Seg7Pat6 = 7'h7D;
  localparam logic [6:0] Seg7Pat7 = 7'h07;
  localparam logic [6:0] Seg7Pat8 = 7'h7F;
  localparam logic [6:0] Seg7Pat9 = 7'h6F;
  localparam logic [6:0] Seg7PatA = 7'h77;
  localparam logic [6:0] Seg7PatB = 7'h7C;
  localparam logic [6:0] Seg7PatC = 7'h39;
  localparam logic [6:0] Seg7PatD = 7'h5E;
  localparam logic [6:0] Seg7PatE = 7'h79;
  localparam logic [6:0] Seg7PatF = 7'h71;

  // Map a lit segment pattern back to its hex nibble; anything else is illegal.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] pattern);
    seg7_dec_t r;
    r.legal  = 1'b1;
    r.nibble = 4'h0;
    case (pattern)
      Seg7Pat0: r.nibble = 4'h0;
      Seg7Pat1: r.nibble = 4'h1;
      Seg7Pat2: r.nibble = 4'h2;
      Seg7Pat3: r.nibble = 4'h3;
      Seg7Pat4: r.nibble = 4'h4;
      Seg7Pat5: r.nibble = 4'h5;
      Seg7Pat6: r.nibble = 4'h6;
      Seg7Pat7: r.nibble = 4'h7;
      Seg7Pat8: r.nibble = 4'h8;
      Seg7Pat9: r.nibble = 4'h9;
      Seg7PatA: r.nibble = 4'hA;
      Seg7PatB: r.nibble = 4'hB;
      Seg7PatC: r.nibble = 4'hC;
      Seg7PatD: r.nibble = 4'hD;
      Seg7PatE: r.nibble = 4'hE;
      Seg7PatF: r.nibble = 4'hF;
      default:  r.legal  = 1'b0;
    endcase
    return r;
  endfunction

  // Index of the lit anode; only meaningful when exactly one bit is set.
  function automatic logic [1:0] seg7_digit_idx(input logic [3:0] an_lit);
    seg7_digit_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (an_lit[i]) seg7_digit_idx = 2'(i);
    end
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern lookup, kept separate so encoder checks can reuse it.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal
);

  seg7_dec_t dec;

  assign dec    = seg7_decode(pattern);
  assign nibble = dec.nibble;
  assign legal  = dec.legal;

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the four displayed hex digits from a multiplexed active-low an/seg bus.
// Optional build macro: SEG7_SCAN_SYNC_EN adds a two-flop synchroniser on an/seg.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        err_pattern,
  output logic        err_multi,
  output logic        stale
);

  localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [11:0] bus_raw;

`ifdef SEG7_SCAN_SYNC_EN
  logic [11:0] sync1_q, sync2_q;

  // Two-flop synchroniser; resets to the all-off pin state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {an, seg};
      sync2_q <= sync1_q;
    end
  end
  assign bus_raw = sync2_q;
`else
  assign bus_raw = {an, seg};
`endif

  logic [3:0] an_lit;
  logic [7:0] seg_lit;
  assign an_lit  = ~bus_raw[11:8];
  assign seg_lit = ~bus_raw[7:0];

  state_t        state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [3:0]    an_prev_q;
  logic [7:0]    seg_prev_q;
  logic          changed, one_hot, multi_now, multi_prev, capture;
  logic [1:0]    idx;
  logic [3:0]    dec_nibble;
  logic          dec_legal;

  assign changed    = (an_lit != an_prev_q) || (seg_lit != seg_prev_q);
  assign one_hot    = $onehot(an_lit);
  assign multi_now  = ($countones(an_lit) > 1);
  assign multi_prev = ($countones(an_prev_q) > 1);
  assign idx        = seg7_digit_idx(an_lit);

  seg7_pattern_decode u_decode (
    .pattern (seg_lit[6:0]),
    .nibble  (dec_nibble),
    .legal   (dec_legal)
  );

  // Dwell tracking state and previous bus sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      settle_cnt_q <= '0;
      an_prev_q    <= '0;
      seg_prev_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      an_prev_q    <= an_lit;
      seg_prev_q   <= seg_lit;
    end
  end

  // Dwell FSM: capture once after SETTLE_CYC unchanged edges on a single lit anode.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (one_hot) begin
          state_d      = StSettle;
          settle_cnt_d = '0;
        end
      end
      StSettle: begin
        if (changed) begin
          state_d      = one_hot ? StSettle : StIdle;
          settle_cnt_d = '0;
        end else if (settle_cnt_q == SW'(SETTLE_CYC - 1)) begin
          capture      = 1'b1;
          state_d      = StHeld;
          settle_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (changed) begin
          state_d      = one_hot ? StSettle : StIdle;
          settle_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  logic [15:0]   digits_q, digits_d;
  logic [3:0]    dp_q, dp_d, valid_q, valid_d, seen_q, seen_d;
  logic          frame_q, frame_d, errp_q, errp_d, errm_q, errm_d, stale_q, stale_d;
  logic [TW-1:0] stale_cnt_q, stale_cnt_d;

  // Capture bookkeeping and stale timeout; a capture on the timeout edge wins.
  always_comb begin
    digits_d    = digits_q;
    dp_d        = dp_q;
    valid_d     = valid_q;
    seen_d      = seen_q;
    frame_d     = 1'b0;
    errp_d      = 1'b0;
    errm_d      = multi_now && !multi_prev;
    stale_d     = stale_q;
    stale_cnt_d = stale_cnt_q;
    if (capture) begin
      stale_cnt_d = '0;
      stale_d     = 1'b0;
      if (dec_legal) begin
        digits_d[{idx, 2'b00} +: 4] = dec_nibble;
        valid_d[idx]                = 1'b1;
      end else begin
        valid_d[idx] = 1'b0;
        errp_d       = 1'b1;
      end
      dp_d[idx]   = seg_lit[7];
      seen_d[idx] = 1'b1;
      if (seen_d == 4'b1111) begin
        frame_d = 1'b1;
        seen_d  = '0;
      end
    end else if (stale_cnt_q != TW'(TIMEOUT_CYC)) begin
      stale_cnt_d = stale_cnt_q + 1'b1;
      if (stale_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        stale_d = 1'b1;
        valid_d = '0;
        seen_d  = '0;
      end
    end
  end

  // Output and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q    <= '0;
      dp_q        <= '0;
      valid_q     <= '0;
      seen_q      <= '0;
      frame_q     <= 1'b0;
      errp_q      <= 1'b0;
      errm_q      <= 1'b0;
      stale_q     <= 1'b0;
      stale_cnt_q <= '0;
    end else begin
      digits_q    <= digits_d;
      dp_q        <= dp_d;
      valid_q     <= valid_d;
      seen_q      <= seen_d;
      frame_q     <= frame_d;
      errp_q      <= errp_d;
      errm_q      <= errm_d;
      stale_q     <= stale_d;
      stale_cnt_q <= stale_cnt_d;
    end
  end

  assign digits      = digits_q;
  assign dp          = dp_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign err_pattern = errp_q;
  assign err_multi   = errm_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a run-length reference model predicts the
// outputs after every clock edge, a separate monitor compares them half a cycle later.
module tb_seg7_scan_decoder;

  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = 4'hF;
  logic [7:0]  seg = 8'hFF;
  logic [15:0] digits;
  logic [3:0]  dp, digit_valid;
  logic        frame_valid, err_pattern, err_multi, stale;

  seg7_scan_decoder #(
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .dp          (dp),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err_pattern (err_pattern),
    .err_multi   (err_multi),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  valid;
    logic        frame;
    logic        errp;
    logic        errm;
    logic        stale;
  } obs_t;

  obs_t expq[$];
  int   tests = 0;
  int   failed = 0;
  bit   started = 1'b0;

  // Display table: index = hex value, entry = lit segments (bit0 = a).
  logic [6:0] pats [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (pats[i] == p) return i;
    return -1;
  endfunction

  // Reference model state
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_valid, m_seen;
  logic        m_stale;
  logic [11:0] m_last;
  logic [11:0] m_pipe0, m_pipe1;
  int          m_run, m_since, m_last_cnt;

  always @(posedge clk) begin : model
    obs_t        e;
    logic [11:0] v, lit;
    int          cnt, pos, nib;
    started = 1'b1;
    e = '0;
    if (rst) begin
      m_digits = '0; m_dp = '0; m_valid = '0; m_seen = '0; m_stale = 1'b0;
      m_last = '0; m_run = 0; m_since = 0; m_last_cnt = 0;
      m_pipe0 = '1; m_pipe1 = '1;
    end else begin
`ifdef SEG7_SCAN_SYNC_EN
      v = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = {an, seg};
`else
      v = {an, seg};
`endif
      lit = ~v;
      m_run = (lit == m_last) ? m_run + 1 : 1;
      m_last = lit;
      cnt = $countones(lit[11:8]);
      e.errm = (cnt >= 2) && (m_last_cnt < 2);
      m_last_cnt = cnt;
      // A dwell captures exactly once: the edge where it has been seen SETTLE+1 times.
      if (cnt == 1 && m_run == int'(SETTLE) + 1) begin
        pos = 0;
        for (int i = 0; i < 4; i++) if (lit[8+i]) pos = i;
        nib = lookup(lit[6:0]);
        if (nib >= 0) begin
          m_digits[pos*4 +: 4] = 4'(nib);
          m_valid[pos] = 1'b1;
        end else begin
          m_valid[pos] = 1'b0;
          e.errp = 1'b1;
        end
        m_dp[pos] = lit[7];
        m_seen[pos] = 1'b1;
        if (m_seen == 4'hF) begin
          e.frame = 1'b1;
          m_seen = '0;
        end
        m_since = 0;
        m_stale = 1'b0;
      end else if (m_since < int'(TIMEOUT)) begin
        m_since++;
        if (m_since == int'(TIMEOUT)) begin
          m_stale = 1'b1;
          m_valid = '0;
          m_seen = '0;
        end
      end
      e.digits = m_digits;
      e.dp = m_dp;
      e.valid = m_valid;
      e.stale = m_stale;
    end
    expq.push_back(e);
  end

  // Monitor: compare DUT outputs against the oldest prediction, away from the edge.
  always @(negedge clk) begin : monitor
    obs_t e, got;
    if (started) begin
      tests++;
      if (expq.size() == 0) begin
        failed++;
        $display("FAIL queue_empty at %0t: got no prediction, required one", $time);
      end else begin
        e = expq.pop_front();
        if (rst) e = '0;
        got = {digits, dp, digit_valid, frame_valid, err_pattern, err_multi, stale};
        if (got !== e) begin
          failed++;
          $display("FAIL outputs at %0t: got dig=%h dp=%b val=%b fr=%b ep=%b em=%b st=%b, required dig=%h dp=%b val=%b fr=%b ep=%b em=%b st=%b",
                   $time, got.digits, got.dp, got.valid, got.frame, got.errp, got.errm,
                   got.stale, e.digits, e.dp, e.valid, e.frame, e.errp, e.errm, e.stale);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic put(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    cyc(n);
  endtask

  initial begin
    logic [3:0] a;
    logic [7:0] s;
    int         r, k;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(1);
    // Single digit held well past the settle window: one capture only.
    put(4'b1110, ~8'h06, 10);
    put(4'hF, 8'hFF, 2);
    // Scan "12.34".
    put(4'b0111, ~8'h06, 5);
    put(4'b1011, ~(8'h5B | 8'h80), 5);
    put(4'b1101, ~8'h4F, 5);
    put(4'b1110, ~8'h66, 5);
    // Segments churn faster than the settle window.
    for (int i = 0; i < 6; i++) put(4'b1110, ~{1'b0, pats[i]}, 3);
    // Two anodes lit, then an illegal pattern on one anode.
    put(4'b1100, ~8'h06, 6);
    put(4'b1101, ~8'h49, 6);
    // Scanning stops long enough to go stale, then one capture revives it.
    put(4'hF, 8'hFF, 25);
    put(4'b1011, ~8'h7F, 6);
    // Reset in the middle of a dwell.
    put(4'b0111, ~8'h6D, 2);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(6);
    // Randomised dwells: mostly single legal digits, some blanks, multi-lit and junk.
    for (int d = 0; d < 150; d++) begin
      r = $urandom_range(0, 9);
      k = $urandom_range(0, 3);
      if (r < 7) a = ~(4'b0001 << k);
      else if (r == 7) a = 4'hF;
      else a = ~((4'b0001 << k) | (4'b0001 << ((k + 1) % 4)));
      if ($urandom_range(0, 4) != 0) s = ~{1'($urandom_range(0, 1)), pats[$urandom_range(0, 15)]};
      else s = 8'($urandom);
      put(a, s, $urandom_range(1, 8));
    end
    put(4'hF, 8'hFF, 4);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
